ts_packet_sender: RTL and testbench

Transmit side of the TS path: software loads one 188-byte MPEG-TS packet through the 32-bit register bus, then triggers transmission. The block serialises the packet onto a byte-wide TS output with valid and sync, repeating it on request. Null packets optionally fill idle time. It sits beside the TSP register bank and uses the same address/data bus and the same TS byte-stream format that the replacer/monitor filters consume, so its output can loop back into their mpeg_* inputs.

---
 rtl/ts_packet_sender_pkg.sv | 42 ++++
 rtl/ts_packet_sender_byte_serializer.sv | 56 +++++
 rtl/ts_packet_sender.sv | 179 +++++++++++++++++
 tb/tb_ts_packet_sender.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_packet_sender_pkg.sv
// Shared constants for the TS packet sender: register map, packet geometry,
// null-packet header bytes and the sender FSM state encoding.
package ts_packet_sender_pkg;

  localparam int ADDR_CTRL         = 0;
  localparam int ADDR_SEND         = 1;
  localparam int ADDR_GAP          = 2;
  localparam int ADDR_CC           = 3;
  localparam int ADDR_SENT_COUNT   = 4;
  localparam int ADDR_TS_DATA_BASE = 128;

  localparam int PACK_BYTE_SIZE = 188;
  localparam int PACK_WORD_SIZE = 47;
  localparam logic [7:0] LAST_BYTE_IDX = 8'(PACK_BYTE_SIZE - 1);

  localparam logic [7:0] NULL_HDR0 = 8'h47;
  localparam logic [7:0] NULL_HDR1 = 8'h1F;
  localparam logic [7:0] NULL_HDR2 = 8'hFF;
  localparam logic [7:0] NULL_HDR3 = 8'h10;
  localparam logic [7:0] NULL_FILL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND_USER = 2'd1,
    ST_SEND_NULL = 2'd2,
    ST_GAP       = 2'd3
  } ts_state_e;

  // Null packet: PID 0x1FFF header followed by 0xFF payload.
  function automatic logic [7:0] null_byte(input logic [7:0] idx);
    logic [7:0] b;
    case (idx)
      8'd0:    b = NULL_HDR0;
      8'd1:    b = NULL_HDR1;
      8'd2:    b = NULL_HDR2;
      8'd3:    b = NULL_HDR3;
      default: b = NULL_FILL;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ts_packet_sender_byte_serializer.sv
// Packet buffer (47 x 32) with byte-masked write port, word read port for the
// register bus, and the byte counter plus byte-lane mux feeding the TS output.
module ts_byte_serializer
  import ts_packet_sender_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en_i,
  input  logic [5:0]  wr_idx_i,
  input  logic [31:0] wr_data_i,
  input  logic [3:0]  wr_strb_i,
  input  logic [5:0]  rd_idx_i,
  output logic [31:0] rd_word_o,
  input  logic        start_i,
  input  logic        adv_i,
  output logic [7:0]  byte_idx_o,
  output logic [7:0]  byte_o
);

  logic [31:0] mem_q [PACK_WORD_SIZE];
  logic [7:0]  cnt_q;
  logic [31:0] sel_word;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb_i[b]) mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  // start_i emits byte 0 this cycle, so the counter points at byte 1 next.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= 8'd1;
    end else if (adv_i) begin
      cnt_q <= (cnt_q == LAST_BYTE_IDX) ? 8'd0 : cnt_q + 8'd1;
    end
  end

  assign byte_idx_o = start_i ? 8'd0 : cnt_q;
  assign rd_word_o  = mem_q[rd_idx_i];

  always_comb begin
    sel_word = mem_q[byte_idx_o[7:2]];
    case (byte_idx_o[1:0])
      2'd0:    byte_o = sel_word[7:0];
      2'd1:    byte_o = sel_word[15:8];
      2'd2:    byte_o = sel_word[23:16];
      default: byte_o = sel_word[31:24];
    endcase
  end

endmodule

// File: rtl/ts_packet_sender.sv
// TS packet sender: register bank, send FSM and registered byte-wide TS output.
// TS output is valid-only: a byte is taken whenever ts_out_valid is high; there is no ready.
module ts_packet_sender
  import ts_packet_sender_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int OPT_MEM_ADDR_BITS  = 10,
  parameter int MAX_REPEAT_BITS    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wen,
  input  logic [OPT_MEM_ADDR_BITS-1:0]    waddr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb,
  input  logic                            ren,
  input  logic [OPT_MEM_ADDR_BITS-1:0]    raddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   rdata,
  output logic                            ts_out_valid,
  output logic                            ts_out_sync,
  output logic [7:0]                      ts_out,
  output logic                            busy,
  output ts_state_e                       dbg_state_o
);

  localparam logic [OPT_MEM_ADDR_BITS-1:0] A_CTRL    = OPT_MEM_ADDR_BITS'(ADDR_CTRL);
  localparam logic [OPT_MEM_ADDR_BITS-1:0] A_SEND    = OPT_MEM_ADDR_BITS'(ADDR_SEND);
  localparam logic [OPT_MEM_ADDR_BITS-1:0] A_GAP     = OPT_MEM_ADDR_BITS'(ADDR_GAP);
  localparam logic [OPT_MEM_ADDR_BITS-1:0] A_CC      = OPT_MEM_ADDR_BITS'(ADDR_CC);
  localparam logic [OPT_MEM_ADDR_BITS-1:0] A_SENT    = OPT_MEM_ADDR_BITS'(ADDR_SENT_COUNT);
  localparam logic [OPT_MEM_ADDR_BITS-1:0] A_DATA_LO = OPT_MEM_ADDR_BITS'(ADDR_TS_DATA_BASE);
  localparam logic [OPT_MEM_ADDR_BITS-1:0] A_DATA_HI =
    OPT_MEM_ADDR_BITS'(ADDR_TS_DATA_BASE + PACK_WORD_SIZE - 1);

  ts_state_e                  state_q;
  logic [2:0]                 ctrl_q;
  logic [7:0]                 gap_q;
  logic [7:0]                 gap_cnt_q;
  logic [3:0]                 cc_q;
  logic [31:0]                sent_q;
  logic [MAX_REPEAT_BITS-1:0] rep_q;
  logic                       valid_q;
  logic                       sync_q;
  logic [7:0]                 byte_q;
  logic [31:0]                rdata_q;

  logic                       busy_w;
  logic                       can_eval, launch_user, launch_null;
  logic                       ser_start, ser_adv, last_byte;
  logic                       wr_data_hit, rd_data_hit;
  logic [7:0]                 byte_idx, ser_byte, tx_byte;
  logic [31:0]                rd_word;
  logic [MAX_REPEAT_BITS-1:0] send_val;

  assign busy_w      = (state_q == ST_SEND_USER) || (rep_q != '0);
  assign wr_data_hit = (waddr >= A_DATA_LO) && (waddr <= A_DATA_HI);
  assign rd_data_hit = (raddr >= A_DATA_LO) && (raddr <= A_DATA_HI);
  assign send_val    = (wdata[MAX_REPEAT_BITS-1:0] == '0) ? MAX_REPEAT_BITS'(1)
                                                          : wdata[MAX_REPEAT_BITS-1:0];

  // The launch decision is shared by IDLE and an expired GAP so that a zero
  // gap streams packets back-to-back.
  assign can_eval    = (state_q == ST_IDLE) || ((state_q == ST_GAP) && (gap_cnt_q == 8'd0));
  assign launch_user = ctrl_q[0] && (rep_q != '0);
  assign launch_null = ctrl_q[0] && ctrl_q[1] && !launch_user;
  assign ser_start   = can_eval && (launch_user || launch_null);
  assign ser_adv     = (state_q == ST_SEND_USER) || (state_q == ST_SEND_NULL);
  assign last_byte   = ser_adv && (byte_idx == LAST_BYTE_IDX);

  ts_byte_serializer u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wen && wr_data_hit && !busy_w),
    .wr_idx_i   (6'(waddr - A_DATA_LO)),
    .wr_data_i  (wdata),
    .wr_strb_i  (wstrb),
    .rd_idx_i   (6'(raddr - A_DATA_LO)),
    .rd_word_o  (rd_word),
    .start_i    (ser_start),
    .adv_i      (ser_adv),
    .byte_idx_o (byte_idx),
    .byte_o     (ser_byte)
  );

  always_comb begin
    tx_byte = ser_byte;
    if ((state_q == ST_SEND_NULL) || (can_eval && !launch_user)) begin
      tx_byte = null_byte(byte_idx);
    end else if (ctrl_q[2] && (byte_idx == 8'd3)) begin
      tx_byte = {ser_byte[7:4], cc_q};
    end
  end

  // Register writes come after the FSM so a bus write wins over an
  // end-of-packet update in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      cc_q      <= '0;
      sent_q    <= '0;
      rep_q     <= '0;
      valid_q   <= 1'b0;
      sync_q    <= 1'b0;
      byte_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_GAP: begin
          if (!can_eval) begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
            valid_q   <= 1'b0;
            sync_q    <= 1'b0;
          end else if (launch_user || launch_null) begin
            state_q <= launch_user ? ST_SEND_USER : ST_SEND_NULL;
            valid_q <= 1'b1;
            sync_q  <= 1'b1;
            byte_q  <= tx_byte;
          end else begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
          end
        end
        default: begin
          valid_q <= 1'b1;
          sync_q  <= 1'b0;
          byte_q  <= tx_byte;
          if (last_byte) begin
            state_q   <= ST_GAP;
            gap_cnt_q <= gap_q;
            if (state_q == ST_SEND_USER) begin
              rep_q  <= rep_q - MAX_REPEAT_BITS'(1);
              sent_q <= sent_q + 32'd1;
              if (ctrl_q[2]) cc_q <= cc_q + 4'd1;
            end
          end
        end
      endcase
      if (wen) begin
        case (waddr)
          A_CTRL:  ctrl_q <= wdata[2:0];
          A_SEND:  rep_q  <= send_val;
          A_GAP:   gap_q  <= wdata[7:0];
          A_CC:    cc_q   <= wdata[3:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (ren) begin
      if (rd_data_hit) begin
        rdata_q <= rd_word;
      end else begin
        case (raddr)
          A_CTRL:  rdata_q <= {29'b0, ctrl_q};
          A_SEND:  rdata_q <= {31'b0, busy_w};
          A_GAP:   rdata_q <= {24'b0, gap_q};
          A_CC:    rdata_q <= {28'b0, cc_q};
          A_SENT:  rdata_q <= sent_q;
          default: rdata_q <= 32'hE000_0000 | 32'(raddr);
        endcase
      end
    end
  end

  assign rdata        = rdata_q;
  assign ts_out_valid = valid_q;
  assign ts_out_sync  = sync_q;
  assign ts_out       = byte_q;
  assign busy         = busy_w;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ts_packet_sender.sv
// Directed bench for ts_packet_sender: packet-level expected-byte queue,
// per-cycle output compare, and literal register/timing expectations.
module tb_ts_packet_sender;
  import ts_packet_sender_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wen = 1'b0;
  logic [9:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        ren = 1'b0;
  logic [9:0]  raddr = '0;
  logic [31:0] rdata;
  logic        ts_out_valid, ts_out_sync, busy;
  logic [7:0]  ts_out;
  ts_state_e   dbg_state;

  ts_packet_sender dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wen          (wen),
    .waddr        (waddr),
    .wdata        (wdata),
    .wstrb        (wstrb),
    .ren          (ren),
    .raddr        (raddr),
    .rdata        (rdata),
    .ts_out_valid (ts_out_valid),
    .ts_out_sync  (ts_out_sync),
    .ts_out       (ts_out),
    .busy         (busy),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];          // {sync, byte}
  logic [7:0]  rx_b3_q[$];
  logic [7:0]  pkt[PACK_BYTE_SIZE];
  int          rx_sync_cnt = 0;
  int          last_sync_cyc = 0;
  logic        gap_chk_en = 1'b0;
  int          exp_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- compare process ----------------
  initial begin : compare
    logic [7:0] last_b;
    logic [8:0] e;
    int idle_run, pkt_idx;
    logic have_prev;
    last_b = 8'h00; idle_run = 0; pkt_idx = 0; have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_b = 8'h00; idle_run = 0; have_prev = 1'b0;
      end else begin
        if (!gap_chk_en) have_prev = 1'b0;
        if (ts_out_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_byte: got sync=%0b byte=0x%02h expected no byte (cycle %0d)",
                     ts_out_sync, ts_out, cyc);
          end else begin
            e = exp_q.pop_front();
            check("ts_byte", {23'b0, ts_out_sync, ts_out}, {23'b0, e});
          end
          if (ts_out_sync) begin
            rx_sync_cnt++;
            last_sync_cyc = cyc;
            pkt_idx = 0;
            if (have_prev) check("gap_len", idle_run, exp_gap);
          end else begin
            pkt_idx++;
            check("contiguous", idle_run, 0);
          end
          if (pkt_idx == 3) rx_b3_q.push_back(ts_out);
          last_b = ts_out;
          idle_run = 0;
          have_prev = 1'b1;
        end else begin
          idle_run++;
          check("sync_without_valid", {31'b0, ts_out_sync}, 32'd0);
          check("hold_ts_out", {24'b0, ts_out}, {24'b0, last_b});
        end
      end
    end
  end

  // ---------------- model helpers ----------------
  task automatic push_user(input logic cc_auto, input logic [3:0] cc);
    logic [7:0] b;
    for (int k = 0; k < PACK_BYTE_SIZE; k++) begin
      b = pkt[k];
      if (k == 3 && cc_auto) b = {pkt[3][7:4], cc};
      exp_q.push_back({(k == 0), b});
    end
  endtask

  task automatic push_null();
    logic [7:0] hdr [4];
    hdr = '{8'h47, 8'h1F, 8'hFF, 8'h10};
    for (int k = 0; k < PACK_BYTE_SIZE; k++)
      exp_q.push_back({(k == 0), (k < 4) ? hdr[k] : 8'hFF});
  endtask

  // ---------------- driver tasks ----------------
  task automatic reg_write(input int addr, input logic [31:0] data, input logic [3:0] strb);
    wen = 1'b1; waddr = 10'(addr); wdata = data; wstrb = strb;
    @(posedge clk); #1;
    wen = 1'b0; wstrb = '0;
  endtask

  task automatic reg_read(input int addr, output logic [31:0] data);
    ren = 1'b1; raddr = 10'(addr);
    @(posedge clk); #1;
    ren = 1'b0;
    data = rdata;
  endtask

  task automatic read_check(input string name, input int addr, input logic [31:0] exp);
    logic [31:0] v;
    reg_read(addr, v);
    check(name, v, exp);
  endtask

  task automatic load_buffer();
    for (int w = 0; w < PACK_WORD_SIZE; w++)
      reg_write(ADDR_TS_DATA_BASE + w, {pkt[4*w+3], pkt[4*w+2], pkt[4*w+1], pkt[4*w]}, 4'hF);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
    #1;
    check(name, exp_q.size(), 0);
    repeat (20) @(posedge clk); #1;
  endtask

  task automatic wait_sync(input string name, input int target);
    int n = 0;
    while (rx_sync_cnt < target && n < 3000) begin @(posedge clk); n++; end
    #1;
    check(name, {31'b0, rx_sync_cnt >= target}, 32'd1);
  endtask

  task automatic gap_mode(input logic en, input int g);
    gap_chk_en = 1'b0;
    @(posedge clk); #1;
    exp_gap = g;
    gap_chk_en = en;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int wr_cyc, base, b3_base;
    for (int k = 0; k < PACK_BYTE_SIZE; k++) pkt[k] = 8'(k);
    pkt[0] = 8'h47; pkt[1] = 8'h01; pkt[2] = 8'h00; pkt[3] = 8'h10;

    // Reset values
    repeat (3) @(posedge clk); #1;
    check("rst_valid", {31'b0, ts_out_valid}, 0);
    check("rst_sync", {31'b0, ts_out_sync}, 0);
    check("rst_ts_out", {24'b0, ts_out}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single user packet, latency and SENT_COUNT
    load_buffer();
    reg_write(ADDR_CTRL, 32'h1, 4'hF);
    push_user(1'b0, 4'h0);
    wr_cyc = cyc;
    reg_write(ADDR_SEND, 32'h1, 4'hF);
    wait_drain("drain_single");
    check("first_sync_latency", last_sync_cyc - wr_cyc, 2);
    read_check("sent_after_1", ADDR_SENT_COUNT, 1);
    check("busy_after_1", {31'b0, busy}, 0);
    read_check("send_reg_busy", ADDR_SEND, 0);

    // cc_auto, three repeats, GAP=5
    reg_write(ADDR_CC, 32'd14, 4'hF);
    reg_write(ADDR_GAP, 32'd5, 4'hF);
    reg_write(ADDR_CTRL, 32'h5, 4'hF);
    gap_mode(1'b1, 5);
    b3_base = rx_b3_q.size();
    push_user(1'b1, 4'd14);
    push_user(1'b1, 4'd15);
    push_user(1'b1, 4'd0);
    reg_write(ADDR_SEND, 32'd3, 4'hF);
    wait_drain("drain_cc");
    check("b3_count", rx_b3_q.size() - b3_base, 3);
    if (rx_b3_q.size() >= b3_base + 3) begin
      check("b3_pkt0", {24'b0, rx_b3_q[b3_base]}, 32'h1E);
      check("b3_pkt1", {24'b0, rx_b3_q[b3_base+1]}, 32'h1F);
      check("b3_pkt2", {24'b0, rx_b3_q[b3_base+2]}, 32'h10);
    end
    read_check("cc_after", ADDR_CC, 1);
    read_check("sent_after_cc", ADDR_SENT_COUNT, 4);

    // Back-to-back with GAP=0
    reg_write(ADDR_CTRL, 32'h1, 4'hF);
    reg_write(ADDR_GAP, 32'd0, 4'hF);
    gap_mode(1'b1, 0);
    push_user(1'b0, 4'h0);
    push_user(1'b0, 4'h0);
    reg_write(ADDR_SEND, 32'd2, 4'hF);
    wait_drain("drain_gap0");
    read_check("sent_after_gap0", ADDR_SENT_COUNT, 6);

    // Null fill, then a SEND during the second null packet
    reg_write(ADDR_GAP, 32'd2, 4'hF);
    gap_mode(1'b1, 2);
    base = rx_sync_cnt;
    push_null();
    push_null();
    reg_write(ADDR_CTRL, 32'h3, 4'hF);
    wait_sync("null_second", base + 2);
    repeat (50) @(posedge clk); #1;
    push_user(1'b0, 4'h0);
    reg_write(ADDR_SEND, 32'd1, 4'hF);
    wait_sync("user_after_null", base + 3);
    reg_write(ADDR_CTRL, 32'h0, 4'hF);
    wait_drain("drain_null");
    read_check("sent_after_null", ADDR_SENT_COUNT, 7);
    gap_mode(1'b0, 0);

    // Byte-masked DATA write, then a write while busy is dropped
    reg_write(ADDR_TS_DATA_BASE, 32'hDEADBEEF, 4'b0010);
    pkt[1] = 8'hBE;
    read_check("data_strb", ADDR_TS_DATA_BASE, 32'h1000BE47);
    reg_write(ADDR_CTRL, 32'h1, 4'hF);
    push_user(1'b0, 4'h0);
    reg_write(ADDR_SEND, 32'd1, 4'hF);
    repeat (10) @(posedge clk); #1;
    check("busy_in_flight", {31'b0, busy}, 1);
    reg_write(ADDR_TS_DATA_BASE, 32'h11223344, 4'hF);
    read_check("data_busy_write", ADDR_TS_DATA_BASE, 32'h1000BE47);
    wait_drain("drain_strb");
    read_check("data_after", ADDR_TS_DATA_BASE, 32'h1000BE47);

    // Disable at byte 100: packet completes, then idle
    push_user(1'b0, 4'h0);
    reg_write(ADDR_SEND, 32'd1, 4'hF);
    repeat (101) @(posedge clk); #1;
    reg_write(ADDR_CTRL, 32'h0, 4'hF);
    wait_drain("drain_disable");
    check("busy_after_disable", {31'b0, busy}, 0);
    check("state_after_disable", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    read_check("sent_after_disable", ADDR_SENT_COUNT, 9);

    // Reset at byte 100
    reg_write(ADDR_CTRL, 32'h5, 4'hF);
    push_user(1'b1, 4'h1);
    reg_write(ADDR_SEND, 32'd1, 4'hF);
    repeat (101) @(posedge clk); #1;
    check("pre_reset_valid", {31'b0, ts_out_valid}, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", {31'b0, ts_out_valid}, 0);
    check("mid_rst_sync", {31'b0, ts_out_sync}, 0);
    check("mid_rst_ts_out", {24'b0, ts_out}, 0);
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_rdata", rdata, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    read_check("rst_ctrl", ADDR_CTRL, 0);
    read_check("rst_gap", ADDR_GAP, 0);
    read_check("rst_cc", ADDR_CC, 0);
    read_check("rst_sent", ADDR_SENT_COUNT, 0);
    read_check("rst_send", ADDR_SEND, 0);
    read_check("buf_kept", ADDR_TS_DATA_BASE + 46, 32'hBBBAB9B8);

    // Unmapped reads
    read_check("unmapped_5", 5, 32'hE0000005);
    read_check("unmapped_175", 175, 32'hE00000AF);
    repeat (10) @(posedge clk); #1;
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
